// File: rtl/block_dispatcher.sv
// Block dispatcher: walks every (row, col) block of a mu x mu product and hands each one to the lowest free processor slot.
// Optional build macro DISPATCHER_CYCLE_COUNT_EN adds a busy-cycle counter output (out_cycle_count).
module block_dispatcher #(
    parameter int num_proc    = 4,
    parameter int index_width = 8
) (
    input  logic                              in_clk,
    input  logic                              in_reset,
    input  logic                              in_start,
    input  logic [index_width-1:0]            in_mu,
    output logic [num_proc*index_width-1:0]   out_row_index,
    output logic [num_proc*index_width-1:0]   out_col_index,
    output logic [num_proc-1:0]               out_index_ready,
    input  logic [num_proc-1:0]               in_index_ack,
    input  logic [num_proc-1:0]               in_result_ready,
    output logic                              out_busy,
    output logic                              out_done,
    output logic [2*index_width-1:0]          out_blocks_done
`ifdef DISPATCHER_CYCLE_COUNT_EN
    ,
    output logic [31:0]                       out_cycle_count
`endif
);

    localparam int CW = 2 * index_width;
    localparam logic [index_width-1:0] IDX_ONE = index_width'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_OFFERED = 2'd1,
        SLOT_WORKING = 2'd2
    } slot_t;

    state_t                            state_r;
    slot_t                             slot_r [num_proc];
    logic [index_width-1:0]            mu_r;
    logic [index_width-1:0]            row_r;
    logic [index_width-1:0]            col_r;
    logic [num_proc*index_width-1:0]   row_index_r;
    logic [num_proc*index_width-1:0]   col_index_r;
    logic [num_proc-1:0]               ready_r;
    logic [num_proc-1:0]               result_prev_r;
    logic [CW-1:0]                     blocks_done_r;
    logic                              busy_r;
    logic                              done_r;

    logic [num_proc-1:0]               free_s;
    logic [num_proc-1:0]               completion_s;
    logic [CW-1:0]                     comp_count_s;
    logic [4:0]                        issue_slot_s;
    logic                              issue_valid_s;
    logic [index_width-1:0]            mu_m1_s;
    logic [CW-1:0]                     total_s;

    assign mu_m1_s       = mu_r - IDX_ONE;
    assign total_s       = CW'(mu_r) * CW'(mu_r);
    assign issue_valid_s = (state_r == ST_DISPATCH) && (|free_s);

    // Slot status decode, completion edge detect and lowest-free-slot priority pick
    always_comb begin
        free_s       = '0;
        completion_s = '0;
        comp_count_s = '0;
        issue_slot_s = 5'd0;
        for (int p = 0; p < num_proc; p++) begin
            free_s[p]       = (slot_r[p] == SLOT_FREE);
            completion_s[p] = (slot_r[p] == SLOT_WORKING) && in_result_ready[p] && !result_prev_r[p];
            comp_count_s    = comp_count_s + CW'(completion_s[p]);
        end
        // Walk downwards so the lowest-numbered free slot wins
        for (int p = num_proc - 1; p >= 0; p--) begin
            issue_slot_s = free_s[p] ? 5'(p) : issue_slot_s;
        end
    end

    // Top-level job FSM together with the per-slot handshake FSMs
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_r       <= ST_IDLE;
            mu_r          <= '0;
            row_r         <= '0;
            col_r         <= '0;
            row_index_r   <= '0;
            col_index_r   <= '0;
            ready_r       <= '0;
            result_prev_r <= '0;
            blocks_done_r <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            for (int p = 0; p < num_proc; p++) begin
                slot_r[p] <= SLOT_FREE;
            end
        end else begin
            done_r        <= 1'b0;
            result_prev_r <= in_result_ready;
            blocks_done_r <= blocks_done_r + comp_count_s;

            for (int p = 0; p < num_proc; p++) begin
                case (slot_r[p])
                    SLOT_FREE: begin
                        if (issue_valid_s && (issue_slot_s == 5'(p))) begin
                            slot_r[p]                                   <= SLOT_OFFERED;
                            row_index_r[p*index_width +: index_width]   <= row_r;
                            col_index_r[p*index_width +: index_width]   <= col_r;
                            ready_r[p]                                  <= 1'b1;
                        end
                    end
                    SLOT_OFFERED: begin
                        if (in_index_ack[p]) begin
                            slot_r[p]  <= SLOT_WORKING;
                            ready_r[p] <= 1'b0;
                        end
                    end
                    SLOT_WORKING: begin
                        if (completion_s[p]) begin
                            slot_r[p] <= SLOT_FREE;
                        end
                    end
                    default: begin
                        slot_r[p]  <= SLOT_FREE;
                        ready_r[p] <= 1'b0;
                    end
                endcase
            end

            case (state_r)
                ST_IDLE: begin
                    if (in_start) begin
                        mu_r          <= in_mu;
                        row_r         <= '0;
                        col_r         <= '0;
                        blocks_done_r <= '0;
                        busy_r        <= 1'b1;
                        state_r       <= (in_mu == '0) ? ST_DONE : ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (issue_valid_s) begin
                        if (col_r == mu_m1_s) begin
                            col_r <= '0;
                            if (row_r == mu_m1_s) begin
                                state_r <= ST_DRAIN;
                            end else begin
                                row_r <= row_r + IDX_ONE;
                            end
                        end else begin
                            col_r <= col_r + IDX_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (blocks_done_r == total_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_row_index   = row_index_r;
    assign out_col_index   = col_index_r;
    assign out_index_ready = ready_r;
    assign out_busy        = busy_r;
    assign out_done        = done_r;
    assign out_blocks_done = blocks_done_r;

`ifdef DISPATCHER_CYCLE_COUNT_EN
    logic [31:0] cycle_count_r;

    // Busy-cycle counter, cleared on job acceptance and frozen while idle
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            cycle_count_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && in_start) begin
            cycle_count_r <= 32'd0;
        end else if (busy_r) begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end
    end

    assign out_cycle_count = cycle_count_r;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: per-slot processor models plus an issue scoreboard.
module tb_block_dispatcher;

    localparam int NP = 4;
    localparam int IW = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [IW-1:0]       mu;
    logic [NP*IW-1:0]    row_index;
    logic [NP*IW-1:0]    col_index;
    logic [NP-1:0]       index_ready;
    logic [NP-1:0]       ack;
    logic [NP-1:0]       res;
    logic                busy;
    logic                done;
    logic [2*IW-1:0]     blocks_done;
`ifdef DISPATCHER_CYCLE_COUNT_EN
    logic [31:0]         cycle_count;
`endif

    always #5 clk = ~clk;

    block_dispatcher #(.num_proc(NP), .index_width(IW)) dut (
        .in_clk          (clk),
        .in_reset        (rst_n),
        .in_start        (start),
        .in_mu           (mu),
        .out_row_index   (row_index),
        .out_col_index   (col_index),
        .out_index_ready (index_ready),
        .in_index_ack    (ack),
        .in_result_ready (res),
        .out_busy        (busy),
        .out_done        (done),
        .out_blocks_done (blocks_done)
`ifdef DISPATCHER_CYCLE_COUNT_EN
        ,
        .out_cycle_count (cycle_count)
`endif
    );

    typedef struct {
        int slot;
        int row;
        int col;
    } issue_t;

    issue_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Processor model configuration (ack_dly < 0: never acknowledges)
    int ack_dly  [NP];
    int res_dly  [NP];
    int res_hold [NP];
    bit spur     [NP];

    // Model state and free-running statistics (never cleared; tests use deltas)
    int            pst [NP];
    int            cnt [NP];
    logic [NP-1:0] ready_prev;
    logic [IW-1:0] held_row [NP];
    logic [IW-1:0] held_col [NP];
    int            ready_cycles [NP];
    int            comp_cnt [NP];
    int            done_cnt  = 0;
    int            busy_cyc  = 0;
    int            ready_any = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard compare on every new offer and behavioural processor models
    always @(negedge clk) begin
        if (!rst_n) begin
            ack        = '0;
            res        = '0;
            ready_prev = '0;
            for (int p = 0; p < NP; p++) begin
                pst[p] = 0;
                cnt[p] = 0;
            end
        end else begin
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            for (int p = 0; p < NP; p++) begin
                logic [IW-1:0] r;
                logic [IW-1:0] c;
                r = row_index[p*IW +: IW];
                c = col_index[p*IW +: IW];
                if (index_ready[p]) begin
                    ready_cycles[p]++;
                    ready_any++;
                end
                if (index_ready[p] && !ready_prev[p]) begin
                    held_row[p] = r;
                    held_col[p] = c;
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_issue_slot", 64'(p), 64'hFFFF);
                    end else begin
                        issue_t e;
                        e = exp_q.pop_front();
                        check_val("issue_slot", 64'(p), 64'(e.slot));
                        check_val("issue_row", 64'(r), 64'(e.row));
                        check_val("issue_col", 64'(c), 64'(e.col));
                    end
                end else if (index_ready[p]) begin
                    if ((r !== held_row[p]) || (c !== held_col[p])) begin
                        check_val("index_stable", {r, c}, {held_row[p], held_col[p]});
                    end
                end
                ready_prev[p] = index_ready[p];

                case (pst[p])
                    0: if (index_ready[p] && (ack_dly[p] >= 0)) begin
                        if (spur[p]) res[p] = 1'b1;
                        if (ack_dly[p] == 0) begin
                            ack[p] = 1'b1;
                            pst[p] = 2;
                        end else begin
                            cnt[p] = ack_dly[p];
                            pst[p] = 1;
                        end
                    end
                    1: begin
                        res[p] = 1'b0;
                        cnt[p]--;
                        if (cnt[p] <= 0) begin
                            ack[p] = 1'b1;
                            pst[p] = 2;
                        end
                    end
                    2: begin
                        ack[p] = 1'b0;
                        cnt[p] = res_dly[p];
                        pst[p] = 3;
                    end
                    3: begin
                        cnt[p]--;
                        if (cnt[p] <= 0) begin
                            res[p] = 1'b1;
                            cnt[p] = res_hold[p];
                            pst[p] = 4;
                        end
                    end
                    4: begin
                        cnt[p]--;
                        if (cnt[p] <= 0) begin
                            res[p] = 1'b0;
                            comp_cnt[p]++;
                            pst[p] = 0;
                        end
                    end
                    default: pst[p] = 0;
                endcase
            end
        end
    end

    task automatic set_proc(input int p, input int ad, input int rd, input int rh, input bit sp);
        ack_dly[p]  = ad;
        res_dly[p]  = rd;
        res_hold[p] = rh;
        spur[p]     = sp;
    endtask

    task automatic push_issue(input int s, input int r, input int c);
        issue_t e;
        e.slot = s;
        e.row  = r;
        e.col  = c;
        exp_q.push_back(e);
    endtask

    task automatic start_job(input int m);
        @(negedge clk);
        start = 1'b1;
        mu    = IW'(m);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int i;
        i = 0;
        while ((done_cnt == base) && (i < budget)) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        check_val(tag, 64'(done_cnt - base), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        int d0, b0, rc0, c2, ra0;
        rst_n = 1'b0;
        start = 1'b0;
        mu    = '0;
        ack   = '0;
        res   = '0;
        for (int p = 0; p < NP; p++) begin
            set_proc(p, 0, 3, 1, 1'b0);
            ready_cycles[p] = 0;
            comp_cnt[p]     = 0;
        end
        repeat (3) @(negedge clk);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_ready", 64'(index_ready), 64'd0);
        check_val("reset_blocks", 64'(blocks_done), 64'd0);
        check_val("reset_row", 64'(row_index), 64'd0);
        rst_n = 1'b1;

        // mu = 0: done two edges after start, nothing offered
        ra0 = ready_any;
        @(negedge clk);
        start = 1'b1;
        mu    = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check_val("mu0_done_early", 64'(done), 64'd0);
        check_val("mu0_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check_val("mu0_done_pulse", 64'(done), 64'd1);
        check_val("mu0_busy_drop", 64'(busy), 64'd0);
        @(negedge clk);
        check_val("mu0_done_single", 64'(done), 64'd0);
        check_val("mu0_no_ready", 64'(ready_any - ra0), 64'd0);
        check_val("mu0_blocks", 64'(blocks_done), 64'd0);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_val("mu0_cycles", 64'(cycle_count), 64'd1);
`endif

        // mu = 1: ack one cycle after the offer, result ten cycles later
        set_proc(0, 1, 10, 1, 1'b0);
        push_issue(0, 0, 0);
        d0  = done_cnt;
        rc0 = ready_cycles[0];
        start_job(1);
        wait_done("mu1_done_once", d0, 200);
        check_val("mu1_ready_cycles", 64'(ready_cycles[0] - rc0), 64'd2);
        check_val("mu1_blocks", 64'(blocks_done), 64'd1);
        check_val("mu1_sb_empty", 64'(exp_q.size()), 64'd0);

        // mu = 2: immediate acks, one block per slot
        for (int p = 0; p < NP; p++) set_proc(p, 0, 3 + p, 1, 1'b0);
        push_issue(0, 0, 0);
        push_issue(1, 0, 1);
        push_issue(2, 1, 0);
        push_issue(3, 1, 1);
        d0 = done_cnt;
        b0 = busy_cyc;
        start_job(2);
        wait_done("mu2_done_once", d0, 200);
        check_val("mu2_blocks", 64'(blocks_done), 64'd4);
        check_val("mu2_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_val("mu2_cycles", 64'(cycle_count), 64'(busy_cyc - b0));
`endif

        // mu = 3: only slot 2 acknowledges, the others keep their first offer
        for (int p = 0; p < NP; p++) set_proc(p, -1, 2, 1, 1'b0);
        set_proc(2, 0, 2, 1, 1'b0);
        push_issue(0, 0, 0);
        push_issue(1, 0, 1);
        push_issue(2, 0, 2);
        push_issue(3, 1, 0);
        push_issue(2, 1, 1);
        push_issue(2, 1, 2);
        push_issue(2, 2, 0);
        push_issue(2, 2, 1);
        push_issue(2, 2, 2);
        d0 = done_cnt;
        c2 = comp_cnt[2];
        start_job(3);
        for (int i = 0; (i < 400) && (comp_cnt[2] - c2 < 6); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_val("mu3_slot2_completions", 64'(comp_cnt[2] - c2), 64'd6);
        check_val("mu3_blocks", 64'(blocks_done), 64'd6);
        check_val("mu3_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("mu3_held_offers", 64'(index_ready), 64'b1011);
        check_val("mu3_busy", 64'(busy), 64'd1);
        check_val("mu3_sb_empty", 64'(exp_q.size()), 64'd0);
        do_reset();

        // Spurious result while offered, then a long result level on slot 1
        for (int p = 0; p < NP; p++) set_proc(p, 0, 2, 1, 1'b0);
        set_proc(1, 3, 4, 20, 1'b1);
        push_issue(0, 0, 0);
        push_issue(1, 0, 1);
        push_issue(2, 1, 0);
        push_issue(3, 1, 1);
        d0 = done_cnt;
        start_job(2);
        wait_done("spur_done_once", d0, 300);
        check_val("spur_blocks", 64'(blocks_done), 64'd4);
        check_val("spur_sb_empty", 64'(exp_q.size()), 64'd0);
        repeat (25) @(negedge clk);
        check_val("spur_blocks_hold", 64'(blocks_done), 64'd4);

        // Asynchronous reset in the middle of dispatch, then a clean job
        for (int p = 0; p < NP; p++) set_proc(p, -1, 2, 1, 1'b0);
        push_issue(0, 0, 0);
        push_issue(1, 0, 1);
        push_issue(2, 0, 2);
        push_issue(3, 0, 3);
        start_job(4);
        repeat (6) @(negedge clk);
        check_val("rst_pre_ready", 64'(index_ready), 64'b1111);
        check_val("rst_sb_empty", 64'(exp_q.size()), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_ready", 64'(index_ready), 64'd0);
        check_val("rst_async_busy", 64'(busy), 64'd0);
        check_val("rst_async_row_col", 64'(row_index | col_index), 64'd0);
        check_val("rst_async_blocks", 64'(blocks_done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        set_proc(0, 0, 3, 1, 1'b0);
        push_issue(0, 0, 0);
        d0 = done_cnt;
        b0 = busy_cyc;
        start_job(1);
        wait_done("post_rst_done_once", d0, 200);
        check_val("post_rst_blocks", 64'(blocks_done), 64'd1);
        check_val("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef DISPATCHER_CYCLE_COUNT_EN
        check_val("post_rst_cycles", 64'(cycle_count), 64'(busy_cyc - b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
